coupling_gain_slewer: RTL and testbench
=======================================

# coupling_gain_slewer

Downstream stage of the coupling mode controller. It takes the controller's stepped `pac_gain`/`harmonic_gain` targets and rate-limits them into smoothly ramping effective gains. It then applies those gains to the PAC-modulated and harmonic-locked gamma drive signals and produces one saturated coupling output for the gamma oscillator input. This removes the gain discontinuities at mode boundaries that the controller's three-level gain steps would otherwise inject.

## Interface
- `WIDTH`, 18, signal/gain width (signed).
- `FRAC`, 14, fractional bits (Q14; 1.0 = 16384).
- `SLEW_STEP`, 8, maximum gain change per `clk_en` tick, in Q14 LSBs; legal range 1..16384.

- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: update strobe (4 kHz tick); all state holds when low.
- `coupling_mode` in 2: mode code from the controller (00 modulatory, 01 transition, 10 harmonic).
- `pac_gain_tgt` in WIDTH signed: target PAC gain.
- `harmonic_gain_tgt` in WIDTH signed: target harmonic gain.
- `pac_drive` in WIDTH signed: PAC-path drive sample.
- `harmonic_drive` in WIDTH signed: harmonic-path drive sample.
- `pac_gain_eff` out WIDTH signed: slewed PAC gain.
- `harmonic_gain_eff` out WIDTH signed: slewed harmonic gain.
- `coupling_out` out WIDTH signed: mixed, rounded, saturated output.
- `out_valid` out 1: one-cycle pulse when `coupling_out` updates.
- `ramp_active` out 1: high while either effective gain differs from its target.
- `ramp_ticks` out 16: number of `clk_en` ticks in the current or most recent ramp; saturates at 0xFFFF.
- `mode_change` out 1: one-cycle pulse on a `clk_en` tick where `coupling_mode` differs from its previously sampled value.

## Operation
- **Target conditioning.** On each `clk_en` tick, each target is clamped to [0, 16384]. Negative targets become 0; targets above 16384 become 16384.
- **Slew rule.** Per path, with `d` = clamped target − eff:
  - If |d| ≤ SLEW_STEP, then eff := target.
  - Otherwise eff := eff ± SLEW_STEP, moving toward the target.
  - Both paths slew independently.
- **State machine.** Two states:
  - SETTLED: both gains equal their targets.
  - RAMP: otherwise.
  - SETTLED→RAMP on any tick where the clamped target ≠ eff. On that tick `ramp_ticks` := 1.
  - While in RAMP, `ramp_ticks` increments each tick.
  - RAMP→SETTLED on the tick where both gains reach their targets. That tick is counted. `ramp_ticks` then holds its value until the next ramp starts.
  - A target change during RAMP retargets from the current eff. The state stays RAMP and `ramp_ticks` is not reset.
- **Mode tracking.** `coupling_mode` is sampled every tick into `mode_q`; `mode_change` = (mode ≠ mode_q). The mode is informational only; the slew rule depends on the targets alone.
- **Mixer pipeline.** The pipeline advances only on `clk_en`.
  - Stage 1 registers the products `pac_drive*pac_gain_eff` and `harmonic_drive*harmonic_gain_eff`, each 2·WIDTH signed. The gains used are the registered eff values from before this tick's update.
  - Stage 2 computes the sum (2·WIDTH+1 bits), adds 2^(FRAC−1), arithmetic-shifts right by FRAC, and saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Reset values.**
  - `pac_gain_eff` = 16384; `harmonic_gain_eff` = 2048 (matches the controller's reset gains).
  - `coupling_out` = 0; `out_valid` = 0; `ramp_active` = 0; `ramp_ticks` = 0; `mode_change` = 0; `mode_q` = 00; pipeline registers = 0.
- **Reset mid-ramp.** Asserting `rst_n` low returns all outputs to their reset values immediately, with no resume.

## Timing
- **Gain latency.** Effective gains update in the `clk` cycle following a sampled `clk_en`.
- **`ramp_active`** is registered and aligned with the gain update.
- **Output latency.**
  - A drive sample present on `clk_en` tick N appears on `coupling_out` after tick N+1, together with the `out_valid` pulse.
  - `out_valid` is asserted for one `clk` cycle per tick, starting from the second tick after reset.
- **`mode_change`** is asserted in the cycle after the tick that samples the new mode.
- **`clk_en` tied high.** Full throughput: one output per `clk`.
- **Ramp duration.** A full-scale gain swing takes ceil(16384/SLEW_STEP) ticks; the default is 2048 ticks (512 ms at 4 kHz).

## Structure
- **Shared package `coupling_pkg`:**
  - Gain constants GAIN_FULL/HALF/WEAK = 16384/8192/2048.
  - Mode encodings 00/01/10.
  - Q14 ONE constant.
  - State encodings SETTLED/RAMP.
  - The package is also used by the coupling mode controller.
- **Sub-module `gain_slew_unit`:**
  - Clamps one target and applies the slew step.
  - Outputs eff and `at_target`.
  - Instantiated twice.
- **Top level:** FSM, tick counter, mode tracking, and mixer pipeline.

## Test plan
- **Reset then hold.** Reset; targets 16384/2048; drives 8192/8192 → gains stay 16384/2048. `coupling_out` = 8192 + 1024 = 9216 after two ticks; `ramp_active` = 0.
- **Mode swap ramp.** Targets step to 2048/16384 with SLEW_STEP=8 → `ramp_active` rises next cycle. Gains move ±8 per tick and reach target on tick 1792. `ramp_ticks` = 1792, then `ramp_active` = 0.
- **Mid-ramp retarget.** After 500 ticks (pac = 12384), pac target returns to 16384 → pac rises from 12384. `ramp_ticks` keeps counting without reset; settled at total tick 1000.
- **Clamp and non-multiple step.** Targets −500 and 20000 from reset with SLEW_STEP=3000 → pac eff sequence 13384, …, 1384, 0. Harmonic eff sequence 5048, …, 14048, 16384.
- **Saturation and rounding.** Both gains 16384; drives +131071/+131071 → `coupling_out` = +131071. Drives −131072/−131072 → −131072. Drives 1/0 with pac gain 8192 → 1 (round-half-up of 0.5).
- **`clk_en` gating and async reset.** `clk_en` low for 100 cycles mid-ramp → no gain, counter or output change. Assert `rst_n` low mid-ramp → all outputs at reset values within the same cycle. `mode_change` pulses once per mode edge.

Source files
------------

// File: rtl/coupling_pkg.sv
// Shared definitions for the coupling mode controller and its gain slewer:
// Q14 gain levels, mode codes and slewer state encodings.
package coupling_pkg;

  // Q14 unity gain (1.0 = 2^14)
  localparam int Q14_ONE   = 16384;

  // Gain levels produced by the coupling mode controller
  localparam int GAIN_FULL = 16384;
  localparam int GAIN_HALF = 8192;
  localparam int GAIN_WEAK = 2048;

  // Coupling mode codes
  typedef enum logic [1:0] {
    MODE_MODULATORY = 2'b00,
    MODE_TRANSITION = 2'b01,
    MODE_HARMONIC   = 2'b10
  } coupling_mode_e;

  // Gain slewer state
  typedef enum logic {
    ST_SETTLED = 1'b0,
    ST_RAMP    = 1'b1
  } slew_state_e;

endpackage

// File: rtl/gain_slew_unit.sv
// One gain path: clamps the target into [0, 1.0] and moves the effective
// gain toward it by at most SLEW_STEP Q14 LSBs per clk_en tick.
module gain_slew_unit
  import coupling_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int SLEW_STEP  = 8,
  parameter int RESET_GAIN = GAIN_FULL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] tgt,
  output logic signed [WIDTH-1:0] eff,
  output logic                    differs,   // clamped target != current eff
  output logic                    at_target  // eff will equal target after this tick
);

  localparam logic signed [WIDTH-1:0] ONE_G  = WIDTH'(Q14_ONE);
  localparam logic signed [WIDTH-1:0] STEP_G = WIDTH'(SLEW_STEP);
  localparam logic signed [WIDTH:0]   STEP_W = (WIDTH+1)'(SLEW_STEP);

  logic signed [WIDTH-1:0] tgt_c;
  logic signed [WIDTH-1:0] eff_next;
  logic signed [WIDTH:0]   diff;

  // Clamp the target and compute the next slewed gain
  always_comb begin
    // NOTE: every signal is given a value on every path first so no latch is inferred.
    tgt_c    = tgt;
    eff_next = eff;
    if (tgt[WIDTH-1]) begin
      tgt_c = '0;
    end else if (tgt > ONE_G) begin
      tgt_c = ONE_G;
    end
    diff = $signed({tgt_c[WIDTH-1], tgt_c}) - $signed({eff[WIDTH-1], eff});
    if ((diff <= STEP_W) && (diff >= -STEP_W)) begin
      eff_next = tgt_c;
    end else if (diff > 0) begin
      eff_next = eff + STEP_G;
    end else begin
      eff_next = eff - STEP_G;
    end
  end

  assign differs   = (tgt_c != eff);
  assign at_target = (eff_next == tgt_c);

  // Effective gain register, advanced only on ticks
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      eff <= WIDTH'(RESET_GAIN);
    end else if (clk_en) begin
      eff <= eff_next;
    end
  end

endmodule

// File: rtl/coupling_gain_slewer.sv
// Rate-limits the controller's stepped PAC/harmonic gain targets and mixes
// the two gamma drive paths into one rounded, saturated coupling output.
module coupling_gain_slewer
  import coupling_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 14,
  parameter int SLEW_STEP = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic [1:0]              coupling_mode,
  input  logic signed [WIDTH-1:0] pac_gain_tgt,
  input  logic signed [WIDTH-1:0] harmonic_gain_tgt,
  input  logic signed [WIDTH-1:0] pac_drive,
  input  logic signed [WIDTH-1:0] harmonic_drive,
  output logic signed [WIDTH-1:0] pac_gain_eff,
  output logic signed [WIDTH-1:0] harmonic_gain_eff,
  output logic signed [WIDTH-1:0] coupling_out,
  output logic                    out_valid,
  output logic                    ramp_active,
  output logic [15:0]             ramp_ticks,
  output logic                    mode_change
);

  localparam int SW = 2 * WIDTH + 1;
  localparam logic signed [SW-1:0] ROUND_HALF = SW'(2 ** (FRAC - 1));
  localparam logic signed [SW-1:0] OUT_MAX    = SW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] OUT_MIN    = SW'(-(2 ** (WIDTH - 1)));

  logic pac_differs, pac_at_target;
  logic harm_differs, harm_at_target;
  logic settle_now;

  gain_slew_unit #(
    .WIDTH      (WIDTH),
    .SLEW_STEP  (SLEW_STEP),
    .RESET_GAIN (GAIN_FULL)
  ) u_pac_slew (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .tgt       (pac_gain_tgt),
    .eff       (pac_gain_eff),
    .differs   (pac_differs),
    .at_target (pac_at_target)
  );

  gain_slew_unit #(
    .WIDTH      (WIDTH),
    .SLEW_STEP  (SLEW_STEP),
    .RESET_GAIN (GAIN_WEAK)
  ) u_harm_slew (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .tgt       (harmonic_gain_tgt),
    .eff       (harmonic_gain_eff),
    .differs   (harm_differs),
    .at_target (harm_at_target)
  );

  assign settle_now = pac_at_target && harm_at_target;

  slew_state_e state;

  // Ramp FSM: tracks settled/ramping and counts ticks of the current ramp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SETTLED;
      ramp_active <= 1'b0;
      ramp_ticks  <= '0;
    end else if (clk_en) begin
      ramp_active <= !settle_now;
      case (state)
        ST_SETTLED: begin
          if (pac_differs || harm_differs) begin
            ramp_ticks <= 16'd1;
            state      <= settle_now ? ST_SETTLED : ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (ramp_ticks != 16'hFFFF) begin
            ramp_ticks <= ramp_ticks + 16'd1;
          end
          if (settle_now) begin
            state <= ST_SETTLED;
          end
        end
        default: state <= ST_SETTLED;
      endcase
    end
  end

  coupling_mode_e mode_q;

  // Mode tracking: pulse mode_change for one cycle after a tick that sees a new mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_MODULATORY;
      mode_change <= 1'b0;
    end else if (clk_en) begin
      mode_change <= (coupling_mode != mode_q);
      mode_q      <= coupling_mode_e'(coupling_mode);
    end else begin
      mode_change <= 1'b0;
    end
  end

  logic signed [2*WIDTH-1:0] prod_pac;
  logic signed [2*WIDTH-1:0] prod_harm;
  logic                      s1_valid;
  logic signed [SW-1:0]      mix_sum;
  logic signed [SW-1:0]      mix_shifted;
  logic signed [WIDTH-1:0]   mix_sat;

  // Stage 2 arithmetic: sum, round half up, scale back to Q0, saturate
  always_comb begin
    mix_sum     = $signed({prod_pac[2*WIDTH-1], prod_pac})
                + $signed({prod_harm[2*WIDTH-1], prod_harm});
    mix_shifted = (mix_sum + ROUND_HALF) >>> FRAC;
    if (mix_shifted > OUT_MAX) begin
      mix_sat = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (mix_shifted < OUT_MIN) begin
      mix_sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      mix_sat = mix_shifted[WIDTH-1:0];
    end
  end

  // Mixer pipeline: products with pre-update gains, then the saturated sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_pac     <= '0;
      prod_harm    <= '0;
      s1_valid     <= 1'b0;
      coupling_out <= '0;
      out_valid    <= 1'b0;
    end else if (clk_en) begin
      prod_pac     <= pac_drive * pac_gain_eff;
      prod_harm    <= harmonic_drive * harmonic_gain_eff;
      s1_valid     <= 1'b1;
      coupling_out <= mix_sat;
      out_valid    <= s1_valid;
    end else begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coupling_gain_slewer.sv
// Bench for coupling_gain_slewer: two instances (slew step 8 and 3000), an
// integer-arithmetic reference model checked every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_coupling_gain_slewer;

  localparam int W      = 18;
  localparam int STEP_A = 8;
  localparam int STEP_B = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic [1:0] mode = 2'b00;

  logic signed [W-1:0] tgt_p [2];
  logic signed [W-1:0] tgt_h [2];
  logic signed [W-1:0] drv_p [2];
  logic signed [W-1:0] drv_h [2];
  logic signed [W-1:0] pe [2];
  logic signed [W-1:0] he [2];
  logic signed [W-1:0] co [2];
  logic                ov [2];
  logic                ra [2];
  logic                mc [2];
  logic [15:0]         rt [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  coupling_gain_slewer #(.WIDTH(W), .FRAC(14), .SLEW_STEP(STEP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .coupling_mode(mode),
    .pac_gain_tgt(tgt_p[0]), .harmonic_gain_tgt(tgt_h[0]),
    .pac_drive(drv_p[0]), .harmonic_drive(drv_h[0]),
    .pac_gain_eff(pe[0]), .harmonic_gain_eff(he[0]), .coupling_out(co[0]),
    .out_valid(ov[0]), .ramp_active(ra[0]), .ramp_ticks(rt[0]), .mode_change(mc[0])
  );

  coupling_gain_slewer #(.WIDTH(W), .FRAC(14), .SLEW_STEP(STEP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .coupling_mode(mode),
    .pac_gain_tgt(tgt_p[1]), .harmonic_gain_tgt(tgt_h[1]),
    .pac_drive(drv_p[1]), .harmonic_drive(drv_h[1]),
    .pac_gain_eff(pe[1]), .harmonic_gain_eff(he[1]), .coupling_out(co[1]),
    .out_valid(ov[1]), .ramp_active(ra[1]), .ramp_ticks(rt[1]), .mode_change(mc[1])
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_q14(int v);
    if (v < 0) return 0;
    if (v > 16384) return 16384;
    return v;
  endfunction

  function automatic int slew_to(int cur, int tgt, int step);
    int d;
    d = tgt - cur;
    if (d <= step && d >= -step) return tgt;
    return (d > 0) ? cur + step : cur - step;
  endfunction

  function automatic longint sat18(longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  int      m_pe [2];
  int      m_he [2];
  longint  m_out [2];
  int      m_rt [2];
  bit      m_ov [2];
  bit      m_ra [2];
  bit      m_mc [2];
  bit      m_s1v [2];
  bit      m_inr [2];
  longint  m_pp [2];
  longint  m_ph [2];
  logic [1:0] m_mq;
  int      cp, ch, np, nh;
  bit      started, settle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pe[i] <= 16384; m_he[i] <= 2048; m_out[i] <= 0; m_rt[i] <= 0;
        m_ov[i] <= 0; m_ra[i] <= 0; m_mc[i] <= 0; m_s1v[i] <= 0; m_inr[i] <= 0;
        m_pp[i] <= 0; m_ph[i] <= 0;
      end
      m_mq <= 2'b00;
    end else if (clk_en) begin
      for (int i = 0; i < 2; i++) begin
        cp = clamp_q14(int'(tgt_p[i]));
        ch = clamp_q14(int'(tgt_h[i]));
        np = slew_to(m_pe[i], cp, (i == 0) ? STEP_A : STEP_B);
        nh = slew_to(m_he[i], ch, (i == 0) ? STEP_A : STEP_B);
        started = (cp != m_pe[i]) || (ch != m_he[i]);
        settle  = (np == cp) && (nh == ch);
        if (m_inr[i]) m_rt[i] <= (m_rt[i] == 65535) ? 65535 : m_rt[i] + 1;
        else if (started) m_rt[i] <= 1;
        m_inr[i] <= (m_inr[i] || started) && !settle;
        m_ra[i]  <= !settle;
        m_pe[i]  <= np;
        m_he[i]  <= nh;
        m_pp[i]  <= longint'(drv_p[i]) * m_pe[i];
        m_ph[i]  <= longint'(drv_h[i]) * m_he[i];
        m_out[i] <= sat18((m_pp[i] + m_ph[i] + 8192) >>> 14);
        m_ov[i]  <= m_s1v[i];
        m_s1v[i] <= 1'b1;
        m_mc[i]  <= (mode != m_mq);
      end
      m_mq <= mode;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ov[i] <= 1'b0;
        m_mc[i] <= 1'b0;
      end
    end
  end

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model[%0d] pac_gain_eff", i), pe[i], m_pe[i]);
        check($sformatf("model[%0d] harmonic_gain_eff", i), he[i], m_he[i]);
        check($sformatf("model[%0d] coupling_out", i), co[i], m_out[i]);
        check($sformatf("model[%0d] out_valid", i), ov[i], m_ov[i]);
        check($sformatf("model[%0d] ramp_active", i), ra[i], m_ra[i]);
        check($sformatf("model[%0d] ramp_ticks", i), rt[i], m_rt[i]);
        check($sformatf("model[%0d] mode_change", i), mc[i], m_mc[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int pexp[6];
    int hexp[6];
    pexp = '{13384, 10384, 7384, 4384, 1384, 0};
    hexp = '{5048, 8048, 11048, 14048, 16384, 16384};
    for (int i = 0; i < 2; i++) begin
      tgt_p[i] = 18'sd16384; tgt_h[i] = 18'sd2048;
      drv_p[i] = 18'sd8192;  drv_h[i] = 18'sd8192;
    end

    // Reset state
    step(3);
    check("reset pac_gain_eff", pe[0], 16384);
    check("reset harmonic_gain_eff", he[0], 2048);
    check("reset coupling_out", co[0], 0);
    check("reset out_valid", ov[0], 0);
    check("reset ramp_active", ra[0], 0);
    check("reset ramp_ticks", rt[0], 0);
    check("reset mode_change", mc[0], 0);

    // Reset then hold
    rst_n = 1'b1; cmp_en = 1'b1; clk_en = 1'b1;
    step(1);
    check("hold first tick out_valid", ov[0], 0);
    step(1);
    check("hold coupling_out", co[0], 9216);
    check("hold out_valid", ov[0], 1);
    check("hold ramp_active", ra[0], 0);
    check("hold pac gain", pe[0], 16384);

    // Mode swap ramp
    tgt_p[0] = 18'sd2048; tgt_h[0] = 18'sd16384;
    step(1);
    check("swap ramp_active rises", ra[0], 1);
    check("swap ramp_ticks start", rt[0], 1);
    check("swap pac first step", pe[0], 16376);
    check("swap harm first step", he[0], 2056);
    step(1790);
    check("swap ramp_ticks 1791", rt[0], 1791);
    check("swap still ramping", ra[0], 1);
    step(1);
    check("swap pac settled", pe[0], 2048);
    check("swap harm settled", he[0], 16384);
    check("swap ramp_ticks final", rt[0], 1792);
    check("swap ramp_active falls", ra[0], 0);
    step(5);
    check("swap ramp_ticks holds", rt[0], 1792);

    // clk_en gating mid-ramp
    tgt_p[0] = 18'sd16384; tgt_h[0] = 18'sd2048;
    step(100);
    clk_en = 1'b0;
    step(100);
    check("gated pac holds", pe[0], 2848);
    check("gated harm holds", he[0], 15584);
    check("gated ramp_ticks holds", rt[0], 100);
    check("gated out_valid low", ov[0], 0);
    clk_en = 1'b1;
    step(3);

    // Async reset mid-ramp
    rst_n = 1'b0;
    #1;
    check("async rst pac", pe[0], 16384);
    check("async rst harm", he[0], 2048);
    check("async rst out", co[0], 0);
    check("async rst out_valid", ov[0], 0);
    check("async rst ramp_active", ra[0], 0);
    check("async rst ramp_ticks", rt[0], 0);
    step(1);
    rst_n = 1'b1;

    // Mid-ramp retarget
    tgt_p[0] = 18'sd2048; tgt_h[0] = 18'sd16384;
    step(500);
    check("retarget pac at 500", pe[0], 12384);
    check("retarget harm at 500", he[0], 6048);
    check("retarget ramp_ticks 500", rt[0], 500);
    tgt_p[0] = 18'sd16384; tgt_h[0] = 18'sd2048;
    step(499);
    check("retarget ramp_ticks 999", rt[0], 999);
    check("retarget still ramping", ra[0], 1);
    step(1);
    check("retarget pac settled", pe[0], 16384);
    check("retarget harm settled", he[0], 2048);
    check("retarget ramp_ticks 1000", rt[0], 1000);
    check("retarget ramp_active falls", ra[0], 0);

    // Clamp and non-multiple step (instance with step 3000)
    tgt_p[1] = -18'sd500; tgt_h[1] = 18'sd20000;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check($sformatf("clamp pac tick %0d", k + 1), pe[1], pexp[k]);
      check($sformatf("clamp harm tick %0d", k + 1), he[1], hexp[k]);
    end
    check("clamp ramp_ticks", rt[1], 6);
    check("clamp ramp_active", ra[1], 0);

    // Saturation and rounding
    tgt_p[1] = 18'sd16384; tgt_h[1] = 18'sd16384;
    step(6);
    check("sat pac full", pe[1], 16384);
    check("sat harm full", he[1], 16384);
    drv_p[1] = 18'sd131071; drv_h[1] = 18'sd131071;
    step(2);
    check("sat positive", co[1], 131071);
    drv_p[1] = 18'sh20000; drv_h[1] = 18'sh20000;
    step(2);
    check("sat negative", co[1], -131072);
    tgt_p[1] = 18'sd8192;
    step(3);
    check("round pac half", pe[1], 8192);
    drv_p[1] = 18'sd1; drv_h[1] = 18'sd0;
    step(2);
    check("round half up", co[1], 1);

    // Mode change pulses
    mode = 2'b01;
    step(1);
    check("mode 00->01 pulse", mc[0], 1);
    step(1);
    check("mode 01 pulse ends", mc[0], 0);
    mode = 2'b10;
    step(1);
    check("mode 01->10 pulse", mc[0], 1);
    step(1);
    check("mode 10 pulse ends", mc[0], 0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
